// File: rtl/mc_mv_buf_sp.sv
// mc_mv_buf_sp - single-port motion-vector buffer for the MC stage.
//
// DEPTH x (NUM_COMP*COMP_WIDTH) array with per-component write masking,
// a registered and held read port with a one-cycle valid strobe, and a
// clear engine that zero-fills the whole array after reset (optional)
// or on request.
//
// Ports:
//   clk        - clock, rising edge
//   rstn       - asynchronous active-low reset
//   clr_i      - clear request, sampled only in IDLE
//   busy_o     - clear sweep in progress, host accesses ignored
//   clr_done_o - one-cycle pulse when a sweep completes
//   cen_i      - access enable, active low
//   wen_i      - write enable, active low (1 = read)
//   bwen_i     - per-component write enable, active low
//   addr_i     - word address
//   data_i     - write data
//   data_o     - registered read data, held between reads
//   vld_o      - one-cycle pulse when data_o was updated by a read
module mc_mv_buf_sp #(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned COMP_WIDTH   = 10,
    parameter int unsigned NUM_COMP     = 2,
    parameter bit          CLR_ON_RESET = 1'b1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             clr_i,
    output logic                             busy_o,
    output logic                             clr_done_o,
    input  logic                             cen_i,
    input  logic                             wen_i,
    input  logic [NUM_COMP-1:0]              bwen_i,
    input  logic [ADDR_WIDTH-1:0]            addr_i,
    input  logic [NUM_COMP*COMP_WIDTH-1:0]   data_i,
    output logic [NUM_COMP*COMP_WIDTH-1:0]   data_o,
    output logic                             vld_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned W     = NUM_COMP * COMP_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = CLR_ON_RESET ? ST_CLEAR : ST_IDLE;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  vld_q, vld_d;
    logic [W-1:0]          data_q;

    logic                  rd_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [W-1:0]          mem_wdata;
    logic [NUM_COMP-1:0]   mem_wmask;   // active high per component

    logic [W-1:0]          mem [DEPTH];

    // The sweep and the host share the single array port; the sweep
    // owns it whenever the FSM is in CLEAR.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        vld_d     = 1'b0;
        rd_en     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_i;
        mem_wdata = data_i;
        mem_wmask = ~bwen_i;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                mem_wmask = '1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                if (clr_i) begin
                    // Clear wins over a same-cycle host access.
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (!cen_i) begin
                    if (wen_i) begin
                        rd_en = 1'b1;
                        vld_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            if (rd_en) begin
                data_q <= mem[mem_addr];
            end
        end
    end

    // Array contents carry no reset; only the sweep initialises them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned k = 0; k < NUM_COMP; k++) begin
                if (mem_wmask[k]) begin
                    mem[mem_addr][k*COMP_WIDTH +: COMP_WIDTH] <= mem_wdata[k*COMP_WIDTH +: COMP_WIDTH];
                end
            end
        end
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign clr_done_o = done_q;
    assign vld_o      = vld_q;
    assign data_o     = data_q;

endmodule

// File: tb/tb_mc_mv_buf_sp.sv
module tb_mc_mv_buf_sp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: 512 x 2 x 10, clear on reset
    logic        rstn, clr_i, cen_i, wen_i;
    logic [1:0]  bwen_i;
    logic [8:0]  addr_i;
    logic [19:0] data_i;
    logic        busy_o, clr_done_o, vld_o;
    logic [19:0] data_o;

    // Small configuration: 16 x 3 x 10, no clear on reset
    logic        rstn2, clr2, cen2, wen2;
    logic [2:0]  bwen2;
    logic [3:0]  addr2;
    logic [29:0] din2;
    logic        busy2, done2, vld2;
    logic [29:0] dout2;

    mc_mv_buf_sp dut (
        .clk(clk), .rstn(rstn), .clr_i(clr_i), .busy_o(busy_o), .clr_done_o(clr_done_o),
        .cen_i(cen_i), .wen_i(wen_i), .bwen_i(bwen_i), .addr_i(addr_i), .data_i(data_i),
        .data_o(data_o), .vld_o(vld_o)
    );

    mc_mv_buf_sp #(.ADDR_WIDTH(4), .COMP_WIDTH(10), .NUM_COMP(3), .CLR_ON_RESET(1'b0)) dut2 (
        .clk(clk), .rstn(rstn2), .clr_i(clr2), .busy_o(busy2), .clr_done_o(done2),
        .cen_i(cen2), .wen_i(wen2), .bwen_i(bwen2), .addr_i(addr2), .data_i(din2),
        .data_o(dout2), .vld_o(vld2)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [19:0] m1 [512];
    logic [19:0] e_data = '0;
    logic        e_vld = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word after a masked write: every component whose enable bit is 0
    // takes the new value, the rest keep the old one.
    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input int unsigned bw, input int unsigned ncomp);
        logic [63:0] r;
        logic [63:0] base;
        r = old;
        for (int k = 0; k < ncomp; k++) begin
            base = 64'd1 << (10 * k);
            if (((bw >> k) % 2) == 0)
                r = r - ((old / base) % 1024) * base + ((nw / base) % 1024) * base;
        end
        return r;
    endfunction

    task automatic zero_model();
        for (int i = 0; i < 512; i++) m1[i] = '0;
    endtask

    // One host cycle on the default instance, only used while it is idle.
    task automatic cyc(input logic clr, input logic c, input logic w, input logic [1:0] b,
                       input logic [8:0] a, input logic [19:0] d, input string tag);
        clr_i = clr; cen_i = c; wen_i = w; bwen_i = b; addr_i = a; data_i = d;
        tick();
        e_vld = 1'b0;
        if (!clr && !c) begin
            if (w) begin
                e_data = m1[a];
                e_vld  = 1'b1;
            end else begin
                m1[a] = 20'(merge(64'(m1[a]), 64'(d), 32'(b), 2));
            end
        end
        chk({tag, " data"}, 64'(data_o), 64'(e_data));
        chk({tag, " vld"},  64'(vld_o),  64'(e_vld));
        chk({tag, " busy"}, 64'(busy_o), 64'(clr));
        chk({tag, " done"}, 64'(clr_done_o), 64'd0);
        clr_i = 1'b0; cen_i = 1'b1;
    endtask

    // Counts busy observations from now on; hammers addr 5 with writes and
    // optionally pulses clr_i partway through, all of which must be ignored.
    task automatic sweep_wait(input int exp_cycles, input string tag, input bit poke);
        int n;
        n = 0;
        while (busy_o && n < 4 * exp_cycles) begin
            n++;
            chk({tag, " sweep vld"},  64'(vld_o), 64'd0);
            chk({tag, " sweep done"}, 64'(clr_done_o), 64'd0);
            chk({tag, " sweep hold"}, 64'(data_o), 64'(e_data));
            clr_i  = poke && (n == 50);
            cen_i  = 1'b0; wen_i = 1'b0; bwen_i = 2'b00;
            addr_i = 9'd5; data_i = 20'($urandom) | 20'd1;
            tick();
        end
        clr_i = 1'b0; cen_i = 1'b1; wen_i = 1'b1;
        chk({tag, " busy cycles"}, 64'(n), 64'(exp_cycles));
        chk({tag, " done pulse"},  64'(clr_done_o), 64'd1);
        zero_model();
    endtask

    initial begin
        logic [29:0] m2;
        logic [29:0] d2;
        int n;

        rstn = 1'b0; clr_i = 1'b0; cen_i = 1'b1; wen_i = 1'b1; bwen_i = '1; addr_i = '0; data_i = '0;
        rstn2 = 1'b0; clr2 = 1'b0; cen2 = 1'b1; wen2 = 1'b1; bwen2 = '1; addr2 = '0; din2 = '0;
        zero_model();
        repeat (3) tick();

        chk("rst busy", 64'(busy_o), 64'd1);
        chk("rst done", 64'(clr_done_o), 64'd0);
        chk("rst vld",  64'(vld_o), 64'd0);
        chk("rst data", 64'(data_o), 64'd0);

        rstn = 1'b1; rstn2 = 1'b1;
        chk("cfg2 rst busy", 64'(busy2), 64'd0);
        chk("cfg2 rst done", 64'(done2), 64'd0);
        chk("cfg2 rst vld",  64'(vld2), 64'd0);
        chk("cfg2 rst data", 64'(dout2), 64'd0);
        sweep_wait(512, "por", 1'b1);

        // First access right at edge DEPTH, back-to-back reads
        cyc(0, 0, 1, 2'b11, 9'd0,   20'h0, "rd0");
        cyc(0, 0, 1, 2'b11, 9'd255, 20'h0, "rd255");
        cyc(0, 0, 1, 2'b11, 9'd511, 20'h0, "rd511");

        // Full and masked writes to address 7
        cyc(0, 0, 0, 2'b00, 9'd7, {10'h3FF, 10'h155}, "wr7 full");
        cyc(0, 0, 1, 2'b11, 9'd7, 20'h0, "rd7 full");
        chk("rd7 full const", 64'(data_o), 64'hFFD55);
        cyc(0, 0, 0, 2'b10, 9'd7, 20'h00000, "wr7 lo");
        cyc(0, 0, 1, 2'b11, 9'd7, 20'h0, "rd7 lo");
        chk("rd7 lo const", 64'(data_o), 64'hFFC00);

        // Held output across idle cycles
        cyc(0, 0, 1, 2'b11, 9'd7, 20'h0, "rd7 again");
        repeat (3) cyc(0, 1, 1, 2'b11, 9'd7, 20'h0, "idle hold");

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            int op;
            logic [8:0] a;
            op = $urandom_range(0, 3);
            a  = ($urandom_range(0, 9) == 0) ? 9'd511 : 9'($urandom_range(0, 7));
            cyc(0, op == 0, op == 1, 2'($urandom), a, 20'($urandom), "rand");
        end

        // Clear request with a same-cycle write, writes and clr_i during sweep
        cyc(0, 0, 0, 2'b00, 9'd5, 20'h12345, "wr5");
        cyc(0, 0, 1, 2'b11, 9'd5, 20'h0, "rd5 pre");
        cyc(1, 0, 0, 2'b00, 9'd5, 20'hABCDE, "clr+wr5");
        sweep_wait(512, "clr", 1'b1);
        cyc(0, 0, 1, 2'b11, 9'd5, 20'h0, "rd5 post");
        cyc(0, 0, 1, 2'b11, 9'd7, 20'h0, "rd7 post");

        // Reset in the middle of a sweep
        cyc(0, 0, 0, 2'b00, 9'd7, 20'h5A5A5, "wr7 b");
        cyc(0, 0, 1, 2'b11, 9'd7, 20'h0, "rd7 b");
        cyc(1, 1, 1, 2'b11, 9'd0, 20'h0, "clr b");
        repeat (99) tick();
        chk("midsweep busy", 64'(busy_o), 64'd1);
        rstn = 1'b0;
        #1;
        chk("abort data", 64'(data_o), 64'd0);
        chk("abort vld",  64'(vld_o), 64'd0);
        chk("abort done", 64'(clr_done_o), 64'd0);
        chk("abort busy", 64'(busy_o), 64'd1);
        tick(); tick();
        e_data = '0;
        rstn = 1'b1;
        sweep_wait(512, "rerst", 1'b0);
        cyc(0, 0, 1, 2'b11, 9'd7, 20'h0, "rd7 rerst");

        // Small configuration: all eight mask patterns on one address
        m2 = 30'h15555555;
        cen2 = 1'b0; wen2 = 1'b0; bwen2 = 3'b000; addr2 = 4'd3; din2 = m2;
        tick();
        for (int p = 0; p < 8; p++) begin
            d2 = 30'($urandom);
            cen2 = 1'b0; wen2 = 1'b0; bwen2 = 3'(p); addr2 = 4'd3; din2 = d2;
            tick();
            m2 = 30'(merge(64'(m2), 64'(d2), p, 3));
            chk("cfg2 wr vld", 64'(vld2), 64'd0);
            wen2 = 1'b1;
            tick();
            chk("cfg2 mask data", 64'(dout2), 64'(m2));
            chk("cfg2 mask vld",  64'(vld2), 64'd1);
        end
        cen2 = 1'b1; clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        n = 0;
        while (busy2 && n < 100) begin
            n++;
            tick();
        end
        chk("cfg2 busy cycles", 64'(n), 64'd16);
        chk("cfg2 done pulse",  64'(done2), 64'd1);
        cen2 = 1'b0; wen2 = 1'b1; addr2 = 4'd3;
        tick();
        cen2 = 1'b1;
        chk("cfg2 rd3 post clr", 64'(dout2), 64'd0);
        chk("cfg2 rd3 vld",      64'(vld2), 64'd1);
        chk("cfg2 done gone",    64'(done2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
